// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/forwarding scheduler: field widths,
// select and mult/div codes, Tnew classes and the E-stage payload.
package hazard_ctrl_pkg;

  localparam int unsigned RA_W  = 5;
  localparam int unsigned TN_W  = 2;
  localparam int unsigned FS_W  = 2;
  localparam int unsigned MD_W  = 2;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [FS_W-1:0] {
    SEL_REG = 2'd0,
    SEL_M   = 2'd1,
    SEL_W   = 2'd2
  } fwd_sel_e;

  typedef enum logic [MD_W-1:0] {
    MD_NONE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2,
    MD_HILO = 2'd3
  } md_op_e;

  localparam logic [TN_W-1:0] TNEW_ALU  = 2'd1;
  localparam logic [TN_W-1:0] TNEW_LOAD = 2'd2;

  typedef struct packed {
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic [RA_W-1:0] wa;
    logic [TN_W-1:0] tnew;
    md_op_e          md;
  } e_stage_t;

  // Tnew counts down once per stage and holds at zero.
  function automatic logic [TN_W-1:0] sat_dec(input logic [TN_W-1:0] t);
    return (t == '0) ? '0 : t - TN_W'(1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// One forwarding-mux select for an E-stage source: a ready M result beats W,
// and r0 never forwards.
module hazard_ctrl_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [RA_W-1:0] src,
  input  logic [RA_W-1:0] m_wa,
  input  logic [TN_W-1:0] m_tnew,
  input  logic [RA_W-1:0] w_wa,
  output logic [FS_W-1:0] sel
);

  always_comb begin
    sel = SEL_REG;
    if (src != '0) begin
      if (src == m_wa && m_tnew == '0) begin
        sel = SEL_M;
      end else if (src == w_wa) begin
        sel = SEL_W;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forward scheduler for the 5-stage pipeline: Tuse/Tnew hazard detection,
// E bubble insertion, operand forwarding selects and mult/div busy sequencing.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] D_rs,
  input  logic [RA_W-1:0] D_rt,
  input  logic [TN_W-1:0] D_rs_tuse,
  input  logic [TN_W-1:0] D_rt_tuse,
  input  logic            D_we,
  input  logic [RA_W-1:0] D_wa,
  input  logic [TN_W-1:0] D_tnew,
  input  logic [MD_W-1:0] D_md_op,
  output logic            stall,
  output logic [FS_W-1:0] E_sel_rs,
  output logic [FS_W-1:0] E_sel_rt,
  output logic            M_sel_rt,
  output logic            md_busy
);

  e_stage_t         e_q;
  e_stage_t         d_stage;
  logic [RA_W-1:0]  m_rt_q;
  logic [RA_W-1:0]  m_wa_q;
  logic [TN_W-1:0]  m_tnew_q;
  logic [RA_W-1:0]  w_wa_q;
  logic [CNT_W-1:0] md_cnt_q;
  logic [CNT_W-1:0] md_cnt_d;
  logic             rs_haz;
  logic             rt_haz;
  logic             md_haz;
  logic             e_md_start;

  // A source stalls while any older producer in E/M would deliver after it is needed.
  assign rs_haz = (D_rs != '0) &&
                  ((D_rs == e_q.wa && e_q.tnew > D_rs_tuse) ||
                   (D_rs == m_wa_q && m_tnew_q > D_rs_tuse));
  assign rt_haz = (D_rt != '0) &&
                  ((D_rt == e_q.wa && e_q.tnew > D_rt_tuse) ||
                   (D_rt == m_wa_q && m_tnew_q > D_rt_tuse));

  assign e_md_start = (e_q.md == MD_MULT) || (e_q.md == MD_DIV);
  assign md_busy    = (md_cnt_q != '0);
  assign md_haz     = (D_md_op != MD_W'(MD_NONE)) && (md_busy || e_md_start);
  assign stall      = rs_haz || rt_haz || md_haz;
  assign M_sel_rt   = (w_wa_q != '0) && (m_rt_q == w_wa_q);

  // Non-writing instructions carry wa=0 so they can never be matched.
  always_comb begin
    d_stage      = '0;
    d_stage.rs   = D_rs;
    d_stage.rt   = D_rt;
    d_stage.wa   = D_we ? D_wa : '0;
    d_stage.tnew = D_tnew;
    d_stage.md   = md_op_e'(D_md_op);
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (e_q.md == MD_MULT) begin
      md_cnt_d = CNT_W'(MULT_CYCLES);
    end else if (e_q.md == MD_DIV) begin
      md_cnt_d = CNT_W'(DIV_CYCLES);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q      <= '0;
      m_rt_q   <= '0;
      m_wa_q   <= '0;
      m_tnew_q <= '0;
      w_wa_q   <= '0;
      md_cnt_q <= '0;
    end else begin
      e_q      <= stall ? '0 : d_stage;
      m_rt_q   <= e_q.rt;
      m_wa_q   <= e_q.wa;
      m_tnew_q <= sat_dec(e_q.tnew);
      w_wa_q   <= m_wa_q;
      md_cnt_q <= md_cnt_d;
    end
  end

  hazard_ctrl_fwd_sel u_sel_rs (
    .src   (e_q.rs),
    .m_wa  (m_wa_q),
    .m_tnew(m_tnew_q),
    .w_wa  (w_wa_q),
    .sel   (E_sel_rs)
  );

  hazard_ctrl_fwd_sel u_sel_rt (
    .src   (e_q.rt),
    .m_wa  (m_wa_q),
    .m_tnew(m_tnew_q),
    .w_wa  (w_wa_q),
    .sel   (E_sel_rt)
  );

endmodule
